// File: rtl/branch_target_buffer_assoc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_target_buffer_assoc: set-associative BTB, 1-cycle registered lookup |
// | Optional direction counters: define BTB_DIRECTION_COUNTER_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module branch_target_buffer_assoc #(
  parameter int PC_W       = 64,
  parameter int INDEX_BITS = 5,
  parameter int WAYS       = 2
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            en,
  input  logic [PC_W-1:0] current_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] prev_pc,
  input  logic [PC_W-1:0] branch_pc,
  input  logic            was_taken,
  output logic [PC_W-1:0] predicted_branch_pc,
  output logic            predict_hit
);

  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = PC_W - INDEX_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [PC_W-1:0]  tgt_q   [SETS][WAYS];
`ifdef BTB_DIRECTION_COUNTER_EN
  logic [1:0]       ctr_q   [SETS][WAYS];
`endif

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]      lk_tag, up_tag;
  logic                  lk_hit;
  logic [PC_W-1:0]       lk_target;
  logic                  up_hit, free_found, do_upd;
  logic [WAY_W-1:0]      up_way, free_way, victim, alloc_way;

  assign lk_idx = current_pc[INDEX_BITS-1:0];
  assign lk_tag = current_pc[PC_W-1:INDEX_BITS];
  assign up_idx = prev_pc[INDEX_BITS-1:0];
  assign up_tag = prev_pc[PC_W-1:INDEX_BITS];
  assign do_upd = en && upd_valid;

  always_comb begin
    logic qual;
    lk_hit    = 1'b0;
    lk_target = '0;
    for (int w = 0; w < WAYS; w++) begin
`ifdef BTB_DIRECTION_COUNTER_EN
      qual = ctr_q[lk_idx][w][1];
`else
      qual = 1'b1;
`endif
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag) && qual) begin
        lk_hit    = 1'b1;
        lk_target = tgt_q[lk_idx][w];
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    up_hit     = 1'b0;
    up_way     = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit = 1'b1;
        up_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[up_idx][w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
  end

  assign alloc_way = free_found ? free_way : victim;

  generate
    if (WAYS > 1) begin : g_victim_ptr
      logic [WAY_W-1:0] ptr_q [SETS];
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (do_upd && !up_hit && was_taken && !free_found) begin
          ptr_q[up_idx] <= ptr_q[up_idx] + 1'b1;
        end
      end
      assign victim = ptr_q[up_idx];
    end else begin : g_no_victim_ptr
      assign victim = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
    end else if (do_upd) begin
      if (up_hit) begin
`ifndef BTB_DIRECTION_COUNTER_EN
        if (!was_taken) valid_q[up_idx][up_way] <= 1'b0;
`endif
      end else if (was_taken) begin
        valid_q[up_idx][alloc_way] <= 1'b1;
      end
    end
  end

  // Tag and target payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (do_upd) begin
      if (up_hit) begin
        if (was_taken) tgt_q[up_idx][up_way] <= branch_pc;
      end else if (was_taken) begin
        tag_q[up_idx][alloc_way] <= up_tag;
        tgt_q[up_idx][alloc_way] <= branch_pc;
      end
    end
  end

`ifdef BTB_DIRECTION_COUNTER_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= 2'd0;
    end else if (do_upd) begin
      if (up_hit) begin
        if (was_taken && ctr_q[up_idx][up_way] != 2'd3)
          ctr_q[up_idx][up_way] <= ctr_q[up_idx][up_way] + 2'd1;
        else if (!was_taken && ctr_q[up_idx][up_way] != 2'd0)
          ctr_q[up_idx][up_way] <= ctr_q[up_idx][up_way] - 2'd1;
      end else if (was_taken) begin
        ctr_q[up_idx][alloc_way] <= 2'd2;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      predict_hit         <= 1'b0;
      predicted_branch_pc <= '0;
    end else if (en) begin
      predict_hit         <= lk_hit;
      predicted_branch_pc <= lk_target;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer_assoc.sv
`default_nettype none
// Testbench for branch_target_buffer_assoc: directed vectors plus a randomized
// run against a behavioural reference model, all expectations via a queue.
module tb_branch_target_buffer_assoc;

  localparam int SETS = 32;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        en = 1'b0;
  logic [63:0] current_pc = '0;
  logic        upd_valid = 1'b0;
  logic [63:0] prev_pc = '0;
  logic [63:0] branch_pc = '0;
  logic        was_taken = 1'b0;
  logic [63:0] predicted_branch_pc;
  logic        predict_hit;

  branch_target_buffer_assoc #(.PC_W(64), .INDEX_BITS(5), .WAYS(WAYS)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .current_pc(current_pc),
    .upd_valid(upd_valid), .prev_pc(prev_pc), .branch_pc(branch_pc),
    .was_taken(was_taken), .predicted_branch_pc(predicted_branch_pc),
    .predict_hit(predict_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic [63:0] tgt;
  } exp_t;

  typedef struct {
    bit          e;
    logic [63:0] lpc;
    bit          uv;
    logic [63:0] ppc;
    logic [63:0] bpc;
    bit          tk;
    bit          xh;
    logic [63:0] xt;
  } vec_t;

  exp_t sbq[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model state
  bit          mv   [SETS][WAYS];
  logic [58:0] mtag [SETS][WAYS];
  logic [63:0] mtgt [SETS][WAYS];
  int          mctr [SETS][WAYS];
  int          mptr [SETS];
  logic        m_hit;
  logic [63:0] m_tgt;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0; mctr[s][w] = 0;
      end
    end
    m_hit = 0; m_tgt = '0;
  endtask

  task automatic model_cycle(input bit e, input logic [63:0] lpc, input bit uv,
                             input logic [63:0] ppc, input logic [63:0] bpc, input bit tk);
    int idx, hw, fw, aw;
    bit ok;
    if (!e) return;
    idx = int'(lpc[4:0]);
    m_hit = 0; m_tgt = '0;
    for (int w = 0; w < WAYS; w++) begin
`ifdef BTB_DIRECTION_COUNTER_EN
      ok = (mctr[idx][w] >= 2);
`else
      ok = 1;
`endif
      if (mv[idx][w] && mtag[idx][w] == lpc[63:5] && ok) begin
        m_hit = 1; m_tgt = mtgt[idx][w];
      end
    end
    if (!uv) return;
    idx = int'(ppc[4:0]);
    hw = -1; fw = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (mv[idx][w] && mtag[idx][w] == ppc[63:5]) hw = w;
      if (!mv[idx][w] && fw < 0) fw = w;
    end
    if (hw >= 0) begin
`ifdef BTB_DIRECTION_COUNTER_EN
      if (tk) mctr[idx][hw] = (mctr[idx][hw] == 3) ? 3 : mctr[idx][hw] + 1;
      else    mctr[idx][hw] = (mctr[idx][hw] == 0) ? 0 : mctr[idx][hw] - 1;
`else
      if (!tk) mv[idx][hw] = 0;
`endif
      if (tk) mtgt[idx][hw] = bpc;
    end else if (tk) begin
      if (fw >= 0) aw = fw;
      else begin
        aw = mptr[idx];
        mptr[idx] = (mptr[idx] + 1) % WAYS;
      end
      mv[idx][aw] = 1; mtag[idx][aw] = ppc[63:5]; mtgt[idx][aw] = bpc; mctr[idx][aw] = 2;
    end
  endtask

  task automatic drive(input bit e, input logic [63:0] lpc, input bit uv,
                       input logic [63:0] ppc, input logic [63:0] bpc, input bit tk);
    en = e; current_pc = lpc; upd_valid = uv; prev_pc = ppc; branch_pc = bpc; was_taken = tk;
    model_cycle(e, lpc, uv, ppc, bpc, tk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    sbq.push_back('{hit: v.xh, tgt: v.xt});
    drive(v.e, v.lpc, v.uv, v.ppc, v.bpc, v.tk);
  endtask

  task automatic do_reset();
    arst_n = 1'b0; en = 1'b0; upd_valid = 1'b0;
    #2;
    arst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    exp_t x;
    do_reset();
    sbq.push_back('{hit: 1'b0, tgt: 64'h0});
    x = sbq.pop_front();
    n_assert++;
    if (predict_hit !== x.hit || predicted_branch_pc !== x.tgt) begin
      n_fail++;
      $display("FAIL reset_state: hit=%b pc=%h, want hit=%b pc=%h", predict_hit, predicted_branch_pc, x.hit, x.tgt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    vec_t tbl[4] = '{
      '{1, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 64'h0},
      '{1, 64'h0000, 1, 64'h1000, 64'h2000, 1, 0, 64'h0},
      '{1, 64'h1000, 0, 64'h0,    64'h0,    0, 1, 64'h2000},
      '{1, 64'h1001, 0, 64'h0,    64'h0,    0, 0, 64'h0}
    };
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      drive_vec(tbl[i]);
      x = sbq.pop_front();
      n_assert++;
      if (predict_hit !== x.hit || predicted_branch_pc !== x.tgt) begin
        n_fail++;
        $display("FAIL basic[%0d]: hit=%b pc=%h, want hit=%b pc=%h", i, predict_hit, predicted_branch_pc, x.hit, x.tgt);
      end
    end
  endtask

  task automatic test_eviction();
    vec_t tbl[10] = '{
      '{1, 64'h05, 1, 64'h20, 64'hA20, 1, 0, 64'h0},
      '{1, 64'h20, 1, 64'h40, 64'hA40, 1, 1, 64'hA20},
      '{1, 64'h40, 1, 64'h60, 64'hA60, 1, 1, 64'hA40},
      '{1, 64'h20, 0, 64'h0,  64'h0,   0, 0, 64'h0},
      '{1, 64'h40, 0, 64'h0,  64'h0,   0, 1, 64'hA40},
      '{1, 64'h60, 0, 64'h0,  64'h0,   0, 1, 64'hA60},
      '{1, 64'h05, 1, 64'h80, 64'hA80, 1, 0, 64'h0},
      '{1, 64'h40, 0, 64'h0,  64'h0,   0, 0, 64'h0},
      '{1, 64'h60, 0, 64'h0,  64'h0,   0, 1, 64'hA60},
      '{1, 64'h80, 0, 64'h0,  64'h0,   0, 1, 64'hA80}
    };
    exp_t x;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive_vec(tbl[i]);
      x = sbq.pop_front();
      n_assert++;
      if (predict_hit !== x.hit || predicted_branch_pc !== x.tgt) begin
        n_fail++;
        $display("FAIL eviction[%0d]: hit=%b pc=%h, want hit=%b pc=%h", i, predict_hit, predicted_branch_pc, x.hit, x.tgt);
      end
    end
  endtask

  // Not-taken on a fresh entry drops the prediction in either configuration.
  task automatic test_direction();
    vec_t tbl[9] = '{
      '{1, 64'h0007, 1, 64'h1000, 64'h2000, 1, 0, 64'h0},
      '{1, 64'h1000, 1, 64'h1000, 64'h9999, 0, 1, 64'h2000},
      '{1, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 64'h0},
      '{1, 64'h1000, 1, 64'h1000, 64'h2000, 1, 0, 64'h0},
      '{1, 64'h1000, 0, 64'h0,    64'h0,    0, 1, 64'h2000},
      '{1, 64'h1000, 1, 64'h1000, 64'h2400, 1, 1, 64'h2000},
      '{1, 64'h1000, 0, 64'h0,    64'h0,    0, 1, 64'h2400},
      '{0, 64'h0007, 1, 64'h1000, 64'h5000, 1, 1, 64'h2400},
      '{1, 64'h1000, 0, 64'h0,    64'h0,    0, 1, 64'h2400}
    };
    exp_t x;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_vec(tbl[i]);
      x = sbq.pop_front();
      n_assert++;
      if (predict_hit !== x.hit || predicted_branch_pc !== x.tgt) begin
        n_fail++;
        $display("FAIL direction_enable[%0d]: hit=%b pc=%h, want hit=%b pc=%h", i, predict_hit, predicted_branch_pc, x.hit, x.tgt);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t tbl[3] = '{
      '{1, 64'h3000, 1, 64'h3000, 64'h3100, 1, 0, 64'h0},
      '{1, 64'h3000, 0, 64'h0,    64'h0,    0, 1, 64'h3100},
      '{1, 64'h3000, 0, 64'h0,    64'h0,    0, 1, 64'h3100}
    };
    exp_t x;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_vec(tbl[i]);
      x = sbq.pop_front();
      n_assert++;
      if (predict_hit !== x.hit || predicted_branch_pc !== x.tgt) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: hit=%b pc=%h, want hit=%b pc=%h", i, predict_hit, predicted_branch_pc, x.hit, x.tgt);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t tbl[3] = '{
      '{1, 64'h3000, 0, 64'h0, 64'h0, 0, 0, 64'h0},
      '{1, 64'h4000, 0, 64'h0, 64'h0, 0, 0, 64'h0},
      '{1, 64'h1000, 0, 64'h0, 64'h0, 0, 0, 64'h0}
    };
    exp_t x;
    // Outputs currently show a hit on 0x3000; reset mid-cycle must clear them at once.
    #2;
    arst_n = 1'b0;
    #1;
    sbq.push_back('{hit: 1'b0, tgt: 64'h0});
    x = sbq.pop_front();
    n_assert++;
    if (predict_hit !== x.hit || predicted_branch_pc !== x.tgt) begin
      n_fail++;
      $display("FAIL async_reset_immediate: hit=%b pc=%h, want hit=%b pc=%h", predict_hit, predicted_branch_pc, x.hit, x.tgt);
    end
    // Hold reset across an edge with an update presented; it must be discarded.
    en = 1'b1; upd_valid = 1'b1; prev_pc = 64'h4000; branch_pc = 64'h4400; was_taken = 1'b1;
    current_pc = 64'h4000;
    @(posedge clk); #1;
    arst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_vec(tbl[i]);
      x = sbq.pop_front();
      n_assert++;
      if (predict_hit !== x.hit || predicted_branch_pc !== x.tgt) begin
        n_fail++;
        $display("FAIL after_reset[%0d]: hit=%b pc=%h, want hit=%b pc=%h", i, predict_hit, predicted_branch_pc, x.hit, x.tgt);
      end
    end
  endtask

  task automatic test_random();
    exp_t x;
    logic [63:0] lpc, ppc, bpc;
    bit e, uv, tk;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      lpc = {56'($urandom_range(0, 5)), 3'd0, 5'($urandom_range(0, 2))};
      ppc = {56'($urandom_range(0, 5)), 3'd0, 5'($urandom_range(0, 2))};
      bpc = {32'($urandom), 32'($urandom)};
      e   = ($urandom_range(0, 9) != 0);
      uv  = ($urandom_range(0, 1) != 0);
      tk  = ($urandom_range(0, 2) != 0);
      drive(e, lpc, uv, ppc, bpc, tk);
      sbq.push_back('{hit: m_hit, tgt: m_tgt});
      x = sbq.pop_front();
      n_assert++;
      if (predict_hit !== x.hit || predicted_branch_pc !== x.tgt) begin
        n_fail++;
        $display("FAIL random[%0d]: hit=%b pc=%h, want hit=%b pc=%h", i, predict_hit, predicted_branch_pc, x.hit, x.tgt);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_eviction();
    test_direction();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
